drive_sequencer: RTL and testbench

DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

---
 rtl/drive_sequencer_if.sv | 21 ++
 rtl/drive_sequencer.sv | 136 +++++++++++++
 tb/tb_drive_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/drive_sequencer_if.sv
// Drive sequencer bus: operator/sensor inputs and the frame/motor outputs.
// The master side supplies run/sensor; the sequencer (slave) drives the rest.
interface drive_sequencer_if;
    logic        run;
    logic [2:0]  sensor;
    logic [20:0] count_out;
    logic        frame_start;
    logic        dir_l;
    logic        dir_r;
    logic        motor_en;

    modport master (
        output run, sensor,
        input  count_out, frame_start, dir_l, dir_r, motor_en
    );

    modport slave (
        input  run, sensor,
        output count_out, frame_start, dir_l, dir_r, motor_en
    );
endinterface

// File: rtl/drive_sequencer.sv
// Line-following drive sequencer: free-running PWM frame counter plus a
// frame-synchronous steering FSM that sets motor directions once per frame.
module drive_sequencer #(
    parameter int PERIOD       = 2000000,
    parameter int LOST_PERIODS = 50
) (
    input  logic              clk,
    input  logic              reset,
    drive_sequencer_if.slave  bus
);
    localparam int CW = 21;
    localparam int LW = $clog2(LOST_PERIODS + 1);

    typedef enum logic [2:0] {IDLE, FORWARD, TURN_LEFT, TURN_RIGHT, SEARCH, STOP} state_t;
    typedef enum logic [1:0] {NONE, LEFT, RIGHT} turn_t;

    logic          run_s1, run_s2;
    logic [2:0]    sen_s1, sen_s2;
    logic [CW-1:0] cnt;
    logic          frame_start;
    logic          frame_end;
    state_t        state, nxt_state, dec_state;
    turn_t         last_turn, nxt_turn, dec_turn;
    logic [LW-1:0] lost_cnt, nxt_lost;
    logic          dir_l, dir_r, motor_en;
    logic          nxt_l, nxt_r, nxt_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
            sen_s1 <= 3'b000;
            sen_s2 <= 3'b000;
        end else begin
            run_s1 <= bus.run;
            run_s2 <= run_s1;
            sen_s1 <= bus.sensor;
            sen_s2 <= sen_s1;
        end
    end

    assign frame_end = (cnt == CW'(PERIOD - 1));

    // frame_start registers frame_end, so it lines up with count_out = 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= frame_end ? '0 : cnt + CW'(1);
            frame_start <= frame_end;
        end
    end

    always_comb begin
        dec_state = SEARCH;
        dec_turn  = last_turn;
        case (sen_s2)
            3'b010, 3'b101, 3'b111: begin dec_state = FORWARD;    dec_turn = NONE;  end
            3'b100, 3'b110:         begin dec_state = TURN_LEFT;  dec_turn = LEFT;  end
            3'b001, 3'b011:         begin dec_state = TURN_RIGHT; dec_turn = RIGHT; end
            default: ;
        endcase
    end

    always_comb begin
        nxt_state = state;
        nxt_turn  = last_turn;
        nxt_lost  = lost_cnt;
        if (!run_s2) begin
            nxt_state = IDLE;
        end else if (frame_end) begin
            if (sen_s2 != 3'b000) begin
                nxt_state = dec_state;
                nxt_turn  = dec_turn;
                nxt_lost  = '0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (lost_cnt == LW'(LOST_PERIODS - 1))
                            nxt_state = STOP;
                        if (lost_cnt != LW'(LOST_PERIODS))
                            nxt_lost = lost_cnt + LW'(1);
                    end
                    STOP:    ;
                    default: nxt_state = SEARCH;
                endcase
            end
        end
    end

    // Outputs come from the next state so a new direction appears exactly at count_out = 0.
    always_comb begin
        nxt_l  = 1'b0;
        nxt_r  = 1'b0;
        nxt_en = 1'b0;
        case (nxt_state)
            FORWARD:    begin nxt_l = 1'b1; nxt_r = 1'b0; nxt_en = 1'b1; end
            TURN_LEFT:  begin nxt_l = 1'b0; nxt_r = 1'b0; nxt_en = 1'b1; end
            TURN_RIGHT: begin nxt_l = 1'b1; nxt_r = 1'b1; nxt_en = 1'b1; end
            SEARCH: begin
                nxt_en = 1'b1;
                case (nxt_turn)
                    LEFT:    begin nxt_l = 1'b0; nxt_r = 1'b0; end
                    RIGHT:   begin nxt_l = 1'b1; nxt_r = 1'b1; end
                    default: begin nxt_l = 1'b1; nxt_r = 1'b0; end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_turn <= NONE;
            lost_cnt  <= '0;
            dir_l     <= 1'b0;
            dir_r     <= 1'b0;
            motor_en  <= 1'b0;
        end else begin
            state     <= nxt_state;
            last_turn <= nxt_turn;
            lost_cnt  <= nxt_lost;
            dir_l     <= nxt_l;
            dir_r     <= nxt_r;
            motor_en  <= nxt_en;
        end
    end

    assign bus.count_out   = cnt;
    assign bus.frame_start = frame_start;
    assign bus.dir_l       = dir_l;
    assign bus.dir_r       = dir_r;
    assign bus.motor_en    = motor_en;
endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with a short frame (20 cycles) and a
// three-frame lost-line limit; expected values are hand-derived per step.
module tb_drive_sequencer;
    localparam int PERIOD = 20;
    localparam int LOST   = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_cnt;
    bit   exp_fs;

    drive_sequencer_if bus();

    drive_sequencer #(.PERIOD(PERIOD), .LOST_PERIODS(LOST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {dir_l, dir_r, motor_en}
    task automatic chk_out(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, bus.dir_l, bus.dir_r, bus.motor_en}, {29'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        exp_cnt = (exp_cnt == PERIOD - 1) ? 0 : exp_cnt + 1;
        exp_fs  = (exp_cnt == 0);
    endtask

    // Always advances at least one cycle, so goto(0) from 0 runs a full frame.
    task automatic goto(input int v);
        do step(); while (exp_cnt != v);
        chk("cnt_at_target", bus.count_out, exp_cnt);
    endtask

    initial begin
        reset      = 1'b0;
        bus.run    = 1'b0;
        bus.sensor = 3'b000;
        exp_cnt    = 0;
        exp_fs     = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_cnt", bus.count_out, 0);
        chk("rst_fs", bus.frame_start, 0);
        chk_out("rst_out", 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_cnt", bus.count_out, 0);
        reset = 1'b0;

        // Free-running counter with run low
        for (int i = 0; i < 45; i++) begin
            step();
            chk("cnt_run", bus.count_out, exp_cnt);
            chk("fs_run", bus.frame_start, exp_fs);
        end
        chk_out("idle_out", 3'b000);

        // Start: run with centred line
        bus.run    = 1'b1;
        bus.sensor = 3'b010;
        goto(19);
        chk_out("start_pre", 3'b000);
        step();
        chk_out("start_fwd", 3'b101);

        // Turns
        bus.sensor = 3'b110;
        goto(19);
        chk_out("fwd_hold", 3'b101);
        step();
        chk_out("turn_left", 3'b001);
        bus.sensor = 3'b011;
        goto(10);
        chk_out("left_mid", 3'b001);
        goto(19);
        chk_out("left_end", 3'b001);
        goto(0);
        chk_out("turn_right", 3'b111);

        // Lost line: three SEARCH frames then STOP
        bus.sensor = 3'b000;
        for (int f = 0; f < LOST; f++) begin
            goto(0);
            chk_out("search", 3'b111);
        end
        goto(0);
        chk_out("stop", 3'b000);
        goto(0);
        chk_out("stop_hold", 3'b000);
        bus.sensor = 3'b010;
        goto(0);
        chk_out("recover_fwd", 3'b101);

        // Sensor change on the frame_end cycle lands one frame late
        goto(19);
        bus.sensor = 3'b110;
        step();
        chk_out("bnd_old", 3'b101);
        goto(0);
        chk_out("bnd_new", 3'b001);
        bus.sensor = 3'b000;
        goto(0);
        chk_out("search_left", 3'b001);
        bus.sensor = 3'b010;
        goto(0);
        chk_out("fwd_again", 3'b101);

        // Abort by run
        goto(7);
        bus.run = 1'b0;
        repeat (3) step();
        chk_out("abort_run", 3'b000);
        chk("abort_cnt", bus.count_out, 10);
        bus.run = 1'b1;
        goto(0);
        chk_out("rerun_fwd", 3'b101);

        // Async reset mid-frame
        goto(12);
        #2 reset = 1'b1;
        #1;
        chk_out("areset_out", 3'b000);
        chk("areset_cnt", bus.count_out, 0);
        chk("areset_fs", bus.frame_start, 0);
        @(posedge clk);
        #1;
        chk("areset_hold", bus.count_out, 0);
        reset   = 1'b0;
        exp_cnt = 0;
        exp_fs  = 1'b0;
        step();
        chk("post_rst_cnt", bus.count_out, 1);
        chk_out("post_rst_out", 3'b000);
        goto(0);
        chk("post_rst_fs", bus.frame_start, 1);
        chk_out("post_rst_fwd", 3'b101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
